// File: rtl/cpu_types_pkg.sv
// Shared CPU types: request-unit FSM state and index-width helper.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        HALTED = 2'd2
    } ru_state_t;

    // Width of an index into n channels (at least one bit).
    function automatic int unsigned ru_idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/request_unit_mc_if.sv
// Bundle of the request_unit_mc port list with DUT-side and bench-side views.
interface request_unit_mc_if #(
    parameter int unsigned NCH = 2
) (
    input logic CLK
);
    logic           RST;
    logic           iREN;
    logic           ihit;
    logic [NCH-1:0] dREN;
    logic [NCH-1:0] dWEN;
    logic           dhit;
    logic           halt;
    logic           imemREN;
    logic           dmemREN;
    logic           dmemWEN;
    logic [NCH-1:0] dgrant;
    logic           pc_wait;
    logic           dtimeout;

    modport ru (
        input  CLK, RST, iREN, ihit, dREN, dWEN, dhit, halt,
        output imemREN, dmemREN, dmemWEN, dgrant, pc_wait, dtimeout
    );

    modport tb (
        input  CLK, imemREN, dmemREN, dmemWEN, dgrant, pc_wait, dtimeout,
        output RST, iREN, ihit, dREN, dWEN, dhit, halt
    );
endinterface

// File: rtl/request_unit_mc_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after `last` wins.
module rr_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned NCH = 2
) (
    input  logic [NCH-1:0]              req,
    input  logic [ru_idx_w(NCH)-1:0]    last,
    output logic [NCH-1:0]              gnt
);
    localparam int unsigned IW = ru_idx_w(NCH);

    logic [IW-1:0] idx;
    logic          found;

    // Scan channels last+1 .. last+NCH (mod NCH), granting the first requester.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            idx = IW'((32'(last) + k) % NCH);
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/request_unit_mc.sv
// Multi-channel request unit: serialises NCH data requesters onto one dmem
// port (round-robin) and stalls fetch while data traffic is outstanding.
// Optional access timeout: define REQUEST_UNIT_TIMEOUT_EN.
module request_unit_mc
    import cpu_types_pkg::*;
#(
    parameter int unsigned NCH       = 2,
    parameter int unsigned TMO_W     = 8,
    parameter int unsigned TMO_LIMIT = 255
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           iREN,
    input  logic           ihit,
    input  logic [NCH-1:0] dREN,
    input  logic [NCH-1:0] dWEN,
    input  logic           dhit,
    input  logic           halt,
    output logic           imemREN,
    output logic           dmemREN,
    output logic           dmemWEN,
    output logic [NCH-1:0] dgrant,
    output logic           pc_wait,
    output logic           dtimeout
);
    localparam int unsigned IW = ru_idx_w(NCH);

    if (NCH < 1 || NCH > 8 || TMO_LIMIT >= (64'd1 << TMO_W)) begin : g_cfg_bad
        $error("request_unit_mc: NCH out of 1..8 or TMO_LIMIT does not fit in TMO_W bits");
    end

    ru_state_t      state_q, state_d;
    logic [NCH-1:0] pend_r_q, pend_r_d;
    logic [NCH-1:0] pend_w_q, pend_w_d;
    logic [NCH-1:0] gnt_q, gnt_d;
    logic [IW-1:0]  last_q, last_d;
    logic           halt_q, halt_d;

    logic           busy;
    logic           tmo_hit;
    logic           access_done;
    logic [NCH-1:0] arb_req;
    logic [NCH-1:0] arb_gnt;
    logic [IW-1:0]  gnt_idx;

    assign busy        = (state_q == BUSY);
    assign access_done = busy && (dhit || tmo_hit);

    // Pending flags: clear the finished channel first, then accept new sets,
    // so a same-cycle re-request on the granted channel stays pending.
    always_comb begin
        pend_r_d = pend_r_q;
        pend_w_d = pend_w_q;
        if (access_done) begin
            pend_r_d = pend_r_d & ~gnt_q;
            pend_w_d = pend_w_d & ~gnt_q;
        end
        if (ihit && state_q != HALTED) begin
            pend_w_d = pend_w_d | dWEN;
            pend_r_d = pend_r_d | (dREN & ~dWEN);
        end
    end

    // Arbitrate on the post-update flags so a request latched this cycle is
    // granted on the next one.
    assign arb_req = pend_r_d | pend_w_d;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .req  (arb_req),
        .last (last_q),
        .gnt  (arb_gnt)
    );

    // Binary index of the current one-hot grant.
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (gnt_q[i]) gnt_idx = IW'(i);
        end
    end

    // Control FSM: grant from IDLE, release on completion, halt once drained.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        halt_d  = halt_q | halt;
        case (state_q)
            IDLE: begin
                if (|arb_req) begin
                    state_d = BUSY;
                    gnt_d   = arb_gnt;
                end else if (halt_q) begin
                    state_d = HALTED;
                end
            end
            BUSY: begin
                if (access_done) begin
                    state_d = IDLE;
                    last_d  = gnt_idx;
                end
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // State registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            pend_r_q <= '0;
            pend_w_q <= '0;
            gnt_q    <= '0;
            last_q   <= IW'(NCH - 1);
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_r_q <= pend_r_d;
            pend_w_q <= pend_w_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            halt_q   <= halt_d;
        end
    end

`ifdef REQUEST_UNIT_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q, tmo_d;

    assign tmo_hit  = busy && !dhit && (tmo_q == TMO_W'(TMO_LIMIT));
    assign dtimeout = tmo_hit;

    // Timeout counter: zero on BUSY entry, count BUSY cycles without dhit.
    always_comb begin
        tmo_d = tmo_q;
        if (state_q == IDLE && state_d == BUSY) begin
            tmo_d = '0;
        end else if (busy && !dhit) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    assign tmo_hit  = 1'b0;
    assign dtimeout = 1'b0;
`endif

    assign dgrant  = busy ? gnt_q : '0;
    assign dmemREN = busy && |(pend_r_q & gnt_q);
    assign dmemWEN = busy && |(pend_w_q & gnt_q);
    assign pc_wait = |(pend_r_q | pend_w_q) || busy || halt_q;
    assign imemREN = iREN && !pc_wait && (state_q != HALTED);

endmodule

// File: tb/tb_request_unit_mc.sv
// Self-checking bench for request_unit_mc (NCH=2, TMO_LIMIT=4).
module tb_request_unit_mc;
    import cpu_types_pkg::*;

    localparam int NCH       = 2;
    localparam int TMO_W     = 8;
    localparam int TMO_LIMIT = 4;

    logic           CLK = 1'b0;
    logic           RST, iREN, ihit, dhit, halt;
    logic [NCH-1:0] dREN, dWEN;
    logic           imemREN, dmemREN, dmemWEN, pc_wait, dtimeout;
    logic [NCH-1:0] dgrant;

    int total = 0;
    int bad   = 0;

    request_unit_mc #(.NCH(NCH), .TMO_W(TMO_W), .TMO_LIMIT(TMO_LIMIT)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .ihit(ihit), .dREN(dREN), .dWEN(dWEN),
        .dhit(dhit), .halt(halt), .imemREN(imemREN), .dmemREN(dmemREN),
        .dmemWEN(dmemWEN), .dgrant(dgrant), .pc_wait(pc_wait), .dtimeout(dtimeout)
    );

    always #5 CLK = ~CLK;

    // Reference model state, kept as plain per-channel flags.
    bit        m_pr[NCH];
    bit        m_pw[NCH];
    ru_state_t m_state;
    int        m_gnt, m_last, m_tmo;
    bit        m_halt;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin m_pr[i] = 0; m_pw[i] = 0; end
        m_state = IDLE; m_gnt = 0; m_last = NCH - 1; m_tmo = 0; m_halt = 0;
    endtask

    function automatic bit m_any();
        bit a = 0;
        for (int i = 0; i < NCH; i++) a |= m_pr[i] | m_pw[i];
        return a;
    endfunction

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_step();
        ru_state_t ns = m_state;
        bit done = 0;
        if (m_state == BUSY) begin
            if (dhit) done = 1;
`ifdef REQUEST_UNIT_TIMEOUT_EN
            else if (m_tmo == TMO_LIMIT) done = 1;
            else m_tmo++;
`endif
            if (done) begin
                m_pr[m_gnt] = 0; m_pw[m_gnt] = 0; m_last = m_gnt; ns = IDLE;
            end
        end
        if (ihit && m_state != HALTED)
            for (int i = 0; i < NCH; i++) begin
                if (dWEN[i]) m_pw[i] = 1;
                else if (dREN[i]) m_pr[i] = 1;
            end
        if (m_state == IDLE) begin
            if (m_any()) begin
                for (int k = 1; k <= NCH; k++) begin
                    int c = (m_last + k) % NCH;
                    if (ns != BUSY && (m_pr[c] || m_pw[c])) begin ns = BUSY; m_gnt = c; end
                end
                m_tmo = 0;
            end else if (m_halt) ns = HALTED;
        end
        m_halt |= halt;
        m_state = ns;
    endtask

    task automatic clear_inputs();
        iREN = 0; ihit = 0; dhit = 0; halt = 0; dREN = '0; dWEN = '0;
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        RST = 1; tick(); RST = 0; #1;
    endtask

    task automatic test_reset();
        clear_inputs(); RST = 1; iREN = 1; #2;
        total++; if (dgrant !== 2'b00) begin bad++; $display("FAIL reset.dgrant got=%b want=00", dgrant); end
        total++; if (dmemREN !== 1'b0) begin bad++; $display("FAIL reset.dmemREN got=%b want=0", dmemREN); end
        total++; if (dmemWEN !== 1'b0) begin bad++; $display("FAIL reset.dmemWEN got=%b want=0", dmemWEN); end
        total++; if (pc_wait !== 1'b0) begin bad++; $display("FAIL reset.pc_wait got=%b want=0", pc_wait); end
        total++; if (dtimeout !== 1'b0) begin bad++; $display("FAIL reset.dtimeout got=%b want=0", dtimeout); end
        total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL reset.imemREN got=%b want=1", imemREN); end
        tick(); RST = 0; #1;
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        ihit = 1; dREN = 2'b01; tick(); ihit = 0; dREN = '0; #1;
        total++; if (dmemREN !== 1'b1) begin bad++; $display("FAIL midbusy.pre_dmemREN got=%b want=1", dmemREN); end
        RST = 1; #1;
        total++; if (dmemREN !== 1'b0) begin bad++; $display("FAIL midbusy.dmemREN got=%b want=0", dmemREN); end
        total++; if (dgrant !== 2'b00) begin bad++; $display("FAIL midbusy.dgrant got=%b want=00", dgrant); end
        total++; if (pc_wait !== 1'b0) begin bad++; $display("FAIL midbusy.pc_wait got=%b want=0", pc_wait); end
        tick(); RST = 0; tick();
        total++; if (dgrant !== 2'b00) begin bad++; $display("FAIL midbusy.after_dgrant got=%b want=00", dgrant); end
    endtask

    task automatic test_single_read();
        do_reset();
        iREN = 1; ihit = 1; dREN = 2'b10; tick(); ihit = 0; dREN = '0; #1;
        total++; if (dgrant !== 2'b10) begin bad++; $display("FAIL single.dgrant got=%b want=10", dgrant); end
        total++; if (dmemREN !== 1'b1) begin bad++; $display("FAIL single.dmemREN got=%b want=1", dmemREN); end
        total++; if (dmemWEN !== 1'b0) begin bad++; $display("FAIL single.dmemWEN got=%b want=0", dmemWEN); end
        total++; if (imemREN !== 1'b0) begin bad++; $display("FAIL single.imemREN got=%b want=0", imemREN); end
        tick();
        total++; if (dmemREN !== 1'b1) begin bad++; $display("FAIL single.hold_dmemREN got=%b want=1", dmemREN); end
        dhit = 1; tick(); dhit = 0; #1;
        total++; if (dmemREN !== 1'b0) begin bad++; $display("FAIL single.done_dmemREN got=%b want=0", dmemREN); end
        total++; if (pc_wait !== 1'b0) begin bad++; $display("FAIL single.done_pc_wait got=%b want=0", pc_wait); end
        total++; if (imemREN !== 1'b1) begin bad++; $display("FAIL single.done_imemREN got=%b want=1", imemREN); end
    endtask

    task automatic test_round_robin();
        do_reset();
        ihit = 1; dREN = 2'b11; tick(); ihit = 0; dREN = '0; #1;
        total++; if (dgrant !== 2'b01) begin bad++; $display("FAIL rr.first got=%b want=01", dgrant); end
        dhit = 1; tick(); dhit = 0; #1;
        total++; if (dgrant !== 2'b00) begin bad++; $display("FAIL rr.gap got=%b want=00", dgrant); end
        total++; if (pc_wait !== 1'b1) begin bad++; $display("FAIL rr.gap_pc_wait got=%b want=1", pc_wait); end
        tick();
        total++; if (dgrant !== 2'b10) begin bad++; $display("FAIL rr.second got=%b want=10", dgrant); end
        total++; if (dmemREN !== 1'b1) begin bad++; $display("FAIL rr.second_dmemREN got=%b want=1", dmemREN); end
        dhit = 1; tick(); dhit = 0; #1;
        total++; if (pc_wait !== 1'b0) begin bad++; $display("FAIL rr.end_pc_wait got=%b want=0", pc_wait); end
    endtask

    task automatic test_write_over_read();
        do_reset();
        ihit = 1; dREN = 2'b01; dWEN = 2'b01; tick(); ihit = 0; dREN = '0; dWEN = '0; #1;
        total++; if (dmemWEN !== 1'b1) begin bad++; $display("FAIL wor.dmemWEN got=%b want=1", dmemWEN); end
        total++; if (dmemREN !== 1'b0) begin bad++; $display("FAIL wor.dmemREN got=%b want=0", dmemREN); end
        dhit = 1; ihit = 1; dREN = 2'b01; tick(); dhit = 0; ihit = 0; dREN = '0; #1;
        total++; if (dgrant !== 2'b00) begin bad++; $display("FAIL rereq.gap got=%b want=00", dgrant); end
        total++; if (pc_wait !== 1'b1) begin bad++; $display("FAIL rereq.pending got=%b want=1", pc_wait); end
        tick();
        total++; if (dgrant !== 2'b01) begin bad++; $display("FAIL rereq.dgrant got=%b want=01", dgrant); end
        total++; if (dmemREN !== 1'b1) begin bad++; $display("FAIL rereq.dmemREN got=%b want=1", dmemREN); end
        total++; if (dmemWEN !== 1'b0) begin bad++; $display("FAIL rereq.dmemWEN got=%b want=0", dmemWEN); end
        dhit = 1; tick(); dhit = 0; #1;
    endtask

    task automatic test_timeout();
        do_reset();
        ihit = 1; dREN = 2'b10; tick(); ihit = 0; dREN = '0; #1;
`ifdef REQUEST_UNIT_TIMEOUT_EN
        total++; if (dtimeout !== 1'b0) begin bad++; $display("FAIL tmo.cycle0 got=%b want=0", dtimeout); end
        for (int k = 1; k <= 3; k++) begin
            tick();
            total++; if (dtimeout !== 1'b0) begin bad++; $display("FAIL tmo.cycle%0d got=%b want=0", k, dtimeout); end
        end
        tick();
        total++; if (dtimeout !== 1'b1) begin bad++; $display("FAIL tmo.pulse got=%b want=1", dtimeout); end
        tick();
        total++; if (dtimeout !== 1'b0) begin bad++; $display("FAIL tmo.after got=%b want=0", dtimeout); end
        total++; if (dgrant !== 2'b00) begin bad++; $display("FAIL tmo.dgrant got=%b want=00", dgrant); end
        total++; if (pc_wait !== 1'b0) begin bad++; $display("FAIL tmo.pc_wait got=%b want=0", pc_wait); end
`else
        for (int k = 0; k < 20; k++) begin
            tick();
            total++; if (dtimeout !== 1'b0) begin bad++; $display("FAIL notmo.dtimeout got=%b want=0", dtimeout); end
        end
        total++; if (dgrant !== 2'b10) begin bad++; $display("FAIL notmo.dgrant got=%b want=10", dgrant); end
        total++; if (dmemREN !== 1'b1) begin bad++; $display("FAIL notmo.dmemREN got=%b want=1", dmemREN); end
        dhit = 1; tick(); dhit = 0; #1;
`endif
    endtask

    task automatic test_halt_drain();
        do_reset();
        ihit = 1; dREN = 2'b01; tick(); ihit = 0; dREN = '0; halt = 1; #1;
        total++; if (dmemREN !== 1'b1) begin bad++; $display("FAIL halt.busy got=%b want=1", dmemREN); end
        tick(); halt = 0; iREN = 1; dhit = 1; #1;
        total++; if (imemREN !== 1'b0) begin bad++; $display("FAIL halt.imem_busy got=%b want=0", imemREN); end
        tick(); dhit = 0; #1;
        total++; if (dmemREN !== 1'b0) begin bad++; $display("FAIL halt.drained got=%b want=0", dmemREN); end
        tick();
        total++; if (imemREN !== 1'b0) begin bad++; $display("FAIL halt.imemREN got=%b want=0", imemREN); end
        total++; if (pc_wait !== 1'b1) begin bad++; $display("FAIL halt.pc_wait got=%b want=1", pc_wait); end
        ihit = 1; dREN = 2'b01; tick(); ihit = 0; dREN = '0; tick();
        total++; if (dgrant !== 2'b00) begin bad++; $display("FAIL halt.ignored_dgrant got=%b want=00", dgrant); end
        total++; if (dmemREN !== 1'b0) begin bad++; $display("FAIL halt.ignored_dmemREN got=%b want=0", dmemREN); end
    endtask

    task automatic test_random();
        logic [NCH-1:0] e_g;
        bit e_ren, e_wen, e_pcw, e_imem, e_tmo, busy;
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            iREN = 1'($urandom_range(0, 1));
            ihit = 1'($urandom_range(0, 1));
            dREN = NCH'($urandom);
            dWEN = NCH'($urandom_range(0, 3) == 0 ? $urandom : 0);
            dhit = ($urandom_range(0, 9) < 3);
            halt = ($urandom_range(0, 399) == 0);
            #1;
            busy  = (m_state == BUSY);
            e_g   = busy ? (NCH'(1) << m_gnt) : '0;
            e_ren = busy && m_pr[m_gnt];
            e_wen = busy && m_pw[m_gnt];
            e_pcw = m_any() || busy || m_halt;
            e_imem = iREN && !e_pcw && (m_state != HALTED);
`ifdef REQUEST_UNIT_TIMEOUT_EN
            e_tmo = busy && !dhit && (m_tmo == TMO_LIMIT);
`else
            e_tmo = 0;
`endif
            total++; if (dgrant !== e_g) begin bad++; $display("FAIL rand.dgrant cyc=%0d got=%b want=%b", cyc, dgrant, e_g); end
            total++; if (dmemREN !== e_ren) begin bad++; $display("FAIL rand.dmemREN cyc=%0d got=%b want=%b", cyc, dmemREN, e_ren); end
            total++; if (dmemWEN !== e_wen) begin bad++; $display("FAIL rand.dmemWEN cyc=%0d got=%b want=%b", cyc, dmemWEN, e_wen); end
            total++; if (pc_wait !== e_pcw) begin bad++; $display("FAIL rand.pc_wait cyc=%0d got=%b want=%b", cyc, pc_wait, e_pcw); end
            total++; if (imemREN !== e_imem) begin bad++; $display("FAIL rand.imemREN cyc=%0d got=%b want=%b", cyc, imemREN, e_imem); end
            total++; if (dtimeout !== e_tmo) begin bad++; $display("FAIL rand.dtimeout cyc=%0d got=%b want=%b", cyc, dtimeout, e_tmo); end
            @(posedge CLK);
            model_step();
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        RST = 1;
        test_reset();
        test_reset_mid_busy();
        test_single_read();
        test_round_robin();
        test_write_over_read();
        test_timeout();
        test_halt_drain();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
